// File: rtl/alu_ctrl_decoder_if.sv
// ID -> ID/EX bundle: instruction and pipeline controls in, registered EX controls out.
// The decoder sits on the slave side and the stage feeding it drives the master side.
interface alu_ctrl_decoder_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall;
    logic        flush;

    logic [4:0]  ex_ALUCode;
    logic [1:0]  ex_ALUSrcA;
    logic        ex_ALUSrcB;
    logic [31:0] ex_imm32;
    logic [1:0]  ex_RegDst;
    logic        ex_RegWrite;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        ex_Branch;
    logic        ex_Jump;
    logic        ex_OvfEn;
    logic        ex_valid;
    logic        ex_illegal;

    modport master (
        output id_valid, id_instr, stall, flush,
        input  ex_ALUCode, ex_ALUSrcA, ex_ALUSrcB, ex_imm32, ex_RegDst,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
               ex_Branch, ex_Jump, ex_OvfEn, ex_valid, ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, stall, flush,
        output ex_ALUCode, ex_ALUSrcA, ex_ALUSrcB, ex_imm32, ex_RegDst,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
               ex_Branch, ex_Jump, ex_OvfEn, ex_valid, ex_illegal
    );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// MIPS ID-stage decoder feeding the ID/EX control register.
// Priority on each edge: reset > flush > stall > load; undecodable words become flagged bubbles.
module alu_ctrl_decoder #(
    parameter logic [4:0] RESET_ALUCODE = 5'b00000
) (
    input logic            clk,
    input logic            reset,
    alu_ctrl_decoder_if.slave bus
);

    typedef enum logic [4:0] {
        ALU_ADD, ALU_AND, ALU_XOR, ALU_OR, ALU_NOR, ALU_SUB, ALU_ANDI, ALU_XORI,
        ALU_ORI, ALU_JR, ALU_BEQ, ALU_BNE, ALU_BGEZ, ALU_BGTZ, ALU_BLEZ, ALU_BLTZ,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL
    } alu_code_e;

    typedef struct packed {
        logic [4:0]  alu_code;
        logic [1:0]  src_a;
        logic        src_b;
        logic [31:0] imm32;
        logic [1:0]  reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic        ovf_en;
        logic        valid;
        logic        illegal;
    } ctrl_t;

    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c          = '0;
        c.alu_code = RESET_ALUCODE;
        return c;
    endfunction

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        legal;
    ctrl_t       dec;
    ctrl_t       q;

    assign op       = bus.id_instr[31:26];
    assign funct    = bus.id_instr[5:0];
    assign rt       = bus.id_instr[20:16];
    assign imm_sext = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
    assign imm_zext = {16'h0000, bus.id_instr[15:0]};

    // rs never steers decoding; it is consumed by the register file, not here.
    logic unused_rs;
    assign unused_rs = ^bus.id_instr[25:21];

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec          = bubble_ctrl();
        dec.imm32    = imm_sext;
        legal        = 1'b1;
        case (op)
            6'b000000: begin
                dec.reg_dst   = 2'd1;
                dec.reg_write = 1'b1;
                case (funct)
                    6'b100000: begin dec.alu_code = ALU_ADD; dec.ovf_en = 1'b1; end
                    6'b100001: dec.alu_code = ALU_ADD;
                    6'b100010: begin dec.alu_code = ALU_SUB; dec.ovf_en = 1'b1; end
                    6'b100011: dec.alu_code = ALU_SUB;
                    6'b100100: dec.alu_code = ALU_AND;
                    6'b100101: dec.alu_code = ALU_OR;
                    6'b100110: dec.alu_code = ALU_XOR;
                    6'b100111: dec.alu_code = ALU_NOR;
                    6'b101010: dec.alu_code = ALU_SLT;
                    6'b101011: dec.alu_code = ALU_SLTU;
                    6'b000000: begin dec.alu_code = ALU_SLL; dec.src_a = 2'd1; end
                    6'b000010: begin dec.alu_code = ALU_SRL; dec.src_a = 2'd1; end
                    6'b000011: begin dec.alu_code = ALU_SRA; dec.src_a = 2'd1; end
                    6'b000100: dec.alu_code = ALU_SLL;
                    6'b000110: dec.alu_code = ALU_SRL;
                    6'b000111: dec.alu_code = ALU_SRA;
                    6'b001000: begin
                        dec.alu_code  = ALU_JR;
                        dec.reg_write = 1'b0;
                        dec.jump      = 1'b1;
                    end
                    default:   legal = 1'b0;
                endcase
            end
            6'b011100: begin
                dec.alu_code  = ALU_MUL;
                dec.reg_dst   = 2'd1;
                dec.reg_write = 1'b1;
                legal         = (funct == 6'b000010);
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                dec.src_b     = 1'b1;
                dec.reg_write = 1'b1;
                case (op[2:0])
                    3'b000: begin dec.alu_code = ALU_ADD; dec.ovf_en = 1'b1; end
                    3'b001: dec.alu_code = ALU_ADD;
                    3'b010: dec.alu_code = ALU_SLT;
                    3'b011: dec.alu_code = ALU_SLTU;
                    3'b100: begin dec.alu_code = ALU_ANDI; dec.imm32 = imm_zext; end
                    3'b101: begin dec.alu_code = ALU_ORI;  dec.imm32 = imm_zext; end
                    3'b110: begin dec.alu_code = ALU_XORI; dec.imm32 = imm_zext; end
                    default: begin
                        // lui: shift the zero-extended immediate left by the constant 16.
                        dec.alu_code = ALU_SLL;
                        dec.src_a    = 2'd2;
                        dec.imm32    = imm_zext;
                    end
                endcase
            end
            6'b100011: begin
                dec.alu_code   = ALU_ADD;
                dec.src_b      = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            6'b101011: begin
                dec.alu_code  = ALU_ADD;
                dec.src_b     = 1'b1;
                dec.mem_write = 1'b1;
            end
            6'b000100: begin dec.alu_code = ALU_BEQ;  dec.branch = 1'b1; end
            6'b000101: begin dec.alu_code = ALU_BNE;  dec.branch = 1'b1; end
            6'b000110: begin dec.alu_code = ALU_BLEZ; dec.branch = 1'b1; end
            6'b000111: begin dec.alu_code = ALU_BGTZ; dec.branch = 1'b1; end
            6'b000001: begin
                dec.branch   = 1'b1;
                dec.alu_code = rt[0] ? ALU_BGEZ : ALU_BLTZ;
                legal        = (rt[4:1] == 4'b0000);
            end
            6'b000010: begin dec.alu_code = ALU_ADD; dec.jump = 1'b1; end
            6'b000011: begin
                dec.alu_code  = ALU_ADD;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.reg_dst   = 2'd2;
            end
            default: legal = 1'b0;
        endcase

        // An undecodable word still occupies the slot, but must not have side effects.
        if (!legal) begin
            dec         = bubble_ctrl();
            dec.illegal = 1'b1;
        end
        dec.valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (reset || bus.flush) begin
            q <= bubble_ctrl();
        end else if (!bus.stall) begin
            q <= bus.id_valid ? dec : bubble_ctrl();
        end
    end

    assign bus.ex_ALUCode  = q.alu_code;
    assign bus.ex_ALUSrcA  = q.src_a;
    assign bus.ex_ALUSrcB  = q.src_b;
    assign bus.ex_imm32    = q.imm32;
    assign bus.ex_RegDst   = q.reg_dst;
    assign bus.ex_RegWrite = q.reg_write;
    assign bus.ex_MemRead  = q.mem_read;
    assign bus.ex_MemWrite = q.mem_write;
    assign bus.ex_MemtoReg = q.mem_to_reg;
    assign bus.ex_Branch   = q.branch;
    assign bus.ex_Jump     = q.jump;
    assign bus.ex_OvfEn    = q.ovf_en;
    assign bus.ex_valid    = q.valid;
    assign bus.ex_illegal  = q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Randomized bench for alu_ctrl_decoder against a table-driven instruction-set model.
// Directed checks cover reset, immediates, shifts, REGIMM, stall/flush and illegal words.
module tb_alu_ctrl_decoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_ctrl_decoder_if bus ();

    alu_ctrl_decoder #(.RESET_ALUCODE(5'b00000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // kind: 0 = opcode only, 1 = opcode + funct, 2 = opcode + rt
    // flags: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, Jump, OvfEn}
    // ext: 0 = immediate not meaningful, 1 = sign-extend, 2 = zero-extend
    typedef struct {
        string      name;
        logic [5:0] op;
        int         kind;
        logic [5:0] key;
        logic [4:0] code;
        logic [1:0] srca;
        logic       srcb;
        logic [1:0] rd;
        logic [6:0] flags;
        int         ext;
    } entry_t;

    typedef struct {
        logic [4:0]  code;
        logic [1:0]  srca;
        logic        srcb;
        logic [31:0] imm;
        logic        imm_known;
        logic [1:0]  rd;
        logic [6:0]  flags;
        logic        valid;
        logic        ill;
    } exp_t;

    entry_t tbl[$];
    exp_t   exp_q;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic entry_t mk(string name, logic [5:0] op, int kind, logic [5:0] key,
                                  logic [4:0] code, logic [1:0] srca, logic srcb,
                                  logic [1:0] rd, logic [6:0] flags, int ext);
        entry_t e;
        e.name = name; e.op = op; e.kind = kind; e.key = key; e.code = code;
        e.srca = srca; e.srcb = srcb; e.rd = rd; e.flags = flags; e.ext = ext;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.code = 5'b00000; e.srca = 2'd0; e.srcb = 1'b0; e.imm = 32'h0; e.imm_known = 1'b1;
        e.rd = 2'd0; e.flags = 7'b0; e.valid = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t predict(logic [31:0] w);
        exp_t e;
        logic [5:0] op;
        logic [5:0] funct;
        logic [5:0] rt;
        op    = w[31:26];
        funct = w[5:0];
        rt    = {1'b0, w[20:16]};
        e     = bubble();
        e.valid = 1'b1;
        e.ill   = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i].op == op &&
                (tbl[i].kind == 0 ||
                 (tbl[i].kind == 1 && tbl[i].key == funct) ||
                 (tbl[i].kind == 2 && tbl[i].key == rt))) begin
                e.ill   = 1'b0;
                e.code  = tbl[i].code;
                e.srca  = tbl[i].srca;
                e.srcb  = tbl[i].srcb;
                e.rd    = tbl[i].rd;
                e.flags = tbl[i].flags;
                e.imm_known = (tbl[i].ext != 0);
                e.imm = (tbl[i].ext == 2) ? {16'h0, w[15:0]}
                                          : {{16{w[15]}}, w[15:0]};
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] gen(entry_t e);
        logic [31:0] w;
        w = $urandom;
        w[31:26] = e.op;
        if (e.kind == 1) w[5:0] = e.key;
        if (e.kind == 2) w[20:16] = e.key[4:0];
        return w;
    endfunction

    task automatic check_all(input string tag);
        logic [6:0] got_flags;
        got_flags = {bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg,
                     bus.ex_Branch, bus.ex_Jump, bus.ex_OvfEn};
        check({tag, ".alucode"}, {27'h0, bus.ex_ALUCode}, {27'h0, exp_q.code});
        check({tag, ".srca"},    {30'h0, bus.ex_ALUSrcA}, {30'h0, exp_q.srca});
        check({tag, ".srcb"},    {31'h0, bus.ex_ALUSrcB}, {31'h0, exp_q.srcb});
        check({tag, ".regdst"},  {30'h0, bus.ex_RegDst},  {30'h0, exp_q.rd});
        check({tag, ".flags"},   {25'h0, got_flags},      {25'h0, exp_q.flags});
        check({tag, ".valid"},   {31'h0, bus.ex_valid},   {31'h0, exp_q.valid});
        check({tag, ".illegal"}, {31'h0, bus.ex_illegal}, {31'h0, exp_q.ill});
        if (exp_q.imm_known) check({tag, ".imm32"}, bus.ex_imm32, exp_q.imm);
    endtask

    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [31:0] w, input logic st, input logic fl);
        reset        = rst;
        bus.id_valid = v;
        bus.id_instr = w;
        bus.stall    = st;
        bus.flush    = fl;
        @(posedge clk);
        if (rst || fl)  exp_q = bubble();
        else if (!st)   exp_q = v ? predict(w) : bubble();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        tbl.push_back(mk("add",   6'h00, 1, 6'h20, 5'd0,  2'd0, 1'b0, 2'd1, 7'b1000001, 0));
        tbl.push_back(mk("addu",  6'h00, 1, 6'h21, 5'd0,  2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("sub",   6'h00, 1, 6'h22, 5'd5,  2'd0, 1'b0, 2'd1, 7'b1000001, 0));
        tbl.push_back(mk("subu",  6'h00, 1, 6'h23, 5'd5,  2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("and",   6'h00, 1, 6'h24, 5'd1,  2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("or",    6'h00, 1, 6'h25, 5'd3,  2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("xor",   6'h00, 1, 6'h26, 5'd2,  2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("nor",   6'h00, 1, 6'h27, 5'd4,  2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("slt",   6'h00, 1, 6'h2A, 5'd19, 2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("sltu",  6'h00, 1, 6'h2B, 5'd20, 2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("sll",   6'h00, 1, 6'h00, 5'd16, 2'd1, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("srl",   6'h00, 1, 6'h02, 5'd17, 2'd1, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("sra",   6'h00, 1, 6'h03, 5'd18, 2'd1, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("sllv",  6'h00, 1, 6'h04, 5'd16, 2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("srlv",  6'h00, 1, 6'h06, 5'd17, 2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("srav",  6'h00, 1, 6'h07, 5'd18, 2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("jr",    6'h00, 1, 6'h08, 5'd9,  2'd0, 1'b0, 2'd1, 7'b0000010, 0));
        tbl.push_back(mk("mul",   6'h1C, 1, 6'h02, 5'd21, 2'd0, 1'b0, 2'd1, 7'b1000000, 0));
        tbl.push_back(mk("addi",  6'h08, 0, 6'h00, 5'd0,  2'd0, 1'b1, 2'd0, 7'b1000001, 1));
        tbl.push_back(mk("addiu", 6'h09, 0, 6'h00, 5'd0,  2'd0, 1'b1, 2'd0, 7'b1000000, 1));
        tbl.push_back(mk("slti",  6'h0A, 0, 6'h00, 5'd19, 2'd0, 1'b1, 2'd0, 7'b1000000, 1));
        tbl.push_back(mk("sltiu", 6'h0B, 0, 6'h00, 5'd20, 2'd0, 1'b1, 2'd0, 7'b1000000, 1));
        tbl.push_back(mk("andi",  6'h0C, 0, 6'h00, 5'd6,  2'd0, 1'b1, 2'd0, 7'b1000000, 2));
        tbl.push_back(mk("ori",   6'h0D, 0, 6'h00, 5'd8,  2'd0, 1'b1, 2'd0, 7'b1000000, 2));
        tbl.push_back(mk("xori",  6'h0E, 0, 6'h00, 5'd7,  2'd0, 1'b1, 2'd0, 7'b1000000, 2));
        tbl.push_back(mk("lui",   6'h0F, 0, 6'h00, 5'd16, 2'd2, 1'b1, 2'd0, 7'b1000000, 2));
        tbl.push_back(mk("lw",    6'h23, 0, 6'h00, 5'd0,  2'd0, 1'b1, 2'd0, 7'b1101000, 1));
        tbl.push_back(mk("sw",    6'h2B, 0, 6'h00, 5'd0,  2'd0, 1'b1, 2'd0, 7'b0010000, 1));
        tbl.push_back(mk("beq",   6'h04, 0, 6'h00, 5'd10, 2'd0, 1'b0, 2'd0, 7'b0000100, 1));
        tbl.push_back(mk("bne",   6'h05, 0, 6'h00, 5'd11, 2'd0, 1'b0, 2'd0, 7'b0000100, 1));
        tbl.push_back(mk("blez",  6'h06, 0, 6'h00, 5'd14, 2'd0, 1'b0, 2'd0, 7'b0000100, 1));
        tbl.push_back(mk("bgtz",  6'h07, 0, 6'h00, 5'd13, 2'd0, 1'b0, 2'd0, 7'b0000100, 1));
        tbl.push_back(mk("bltz",  6'h01, 2, 6'h00, 5'd15, 2'd0, 1'b0, 2'd0, 7'b0000100, 1));
        tbl.push_back(mk("bgez",  6'h01, 2, 6'h01, 5'd12, 2'd0, 1'b0, 2'd0, 7'b0000100, 1));
        tbl.push_back(mk("j",     6'h02, 0, 6'h00, 5'd0,  2'd0, 1'b0, 2'd0, 7'b0000010, 0));
        tbl.push_back(mk("jal",   6'h03, 0, 6'h00, 5'd0,  2'd0, 1'b0, 2'd2, 7'b1000010, 0));

        reset = 1'b1; bus.id_valid = 1'b0; bus.id_instr = '0; bus.stall = 1'b0; bus.flush = 1'b0;
        exp_q = bubble();

        // Reset held two cycles with a live add on the input.
        step("reset0", 1'b1, 1'b1, 32'h01095020, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b1, 32'h01095020, 1'b0, 1'b0);
        check("reset_regwrite", {31'h0, bus.ex_RegWrite}, 32'h0);
        check("reset_valid",    {31'h0, bus.ex_valid},    32'h0);
        step("add", 1'b0, 1'b1, 32'h01095020, 1'b0, 1'b0);
        check("add_regdst", {30'h0, bus.ex_RegDst}, 32'd1);
        check("add_ovf",    {31'h0, bus.ex_OvfEn},  32'd1);

        step("addi", 1'b0, 1'b1, 32'h2108FFFF, 1'b0, 1'b0);
        check("addi_imm", bus.ex_imm32, 32'hFFFFFFFF);
        step("ori", 1'b0, 1'b1, 32'h3508FFFF, 1'b0, 1'b0);
        check("ori_imm",  bus.ex_imm32, 32'h0000FFFF);
        check("ori_code", {27'h0, bus.ex_ALUCode}, 32'h08);
        step("lui", 1'b0, 1'b1, 32'h3C081234, 1'b0, 1'b0);
        check("lui_code", {27'h0, bus.ex_ALUCode}, 32'h10);
        check("lui_srca", {30'h0, bus.ex_ALUSrcA}, 32'd2);
        check("lui_imm",  bus.ex_imm32, 32'h00001234);

        step("sra", 1'b0, 1'b1, 32'h00084083, 1'b0, 1'b0);
        check("sra_code", {27'h0, bus.ex_ALUCode}, 32'h12);
        check("sra_srca", {30'h0, bus.ex_ALUSrcA}, 32'd1);
        step("srav", 1'b0, 1'b1, 32'h01094007, 1'b0, 1'b0);
        check("srav_srca", {30'h0, bus.ex_ALUSrcA}, 32'd0);
        step("bgez", 1'b0, 1'b1, 32'h05010003, 1'b0, 1'b0);
        check("bgez_code", {27'h0, bus.ex_ALUCode}, 32'h0C);
        check("bgez_br",   {31'h0, bus.ex_Branch},  32'd1);
        step("bltz", 1'b0, 1'b1, 32'h05000003, 1'b0, 1'b0);
        check("bltz_code", {27'h0, bus.ex_ALUCode}, 32'h0F);
        step("nop", 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0);
        check("nop_regwrite", {31'h0, bus.ex_RegWrite}, 32'd1);

        // Stall holds the lw while the input keeps changing; flush beats stall.
        step("lw", 1'b0, 1'b1, 32'h8D090004, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 1'b1, $urandom, 1'b1, 1'b0);
            check("stall_memread", {31'h0, bus.ex_MemRead}, 32'd1);
            check("stall_code", {27'h0, bus.ex_ALUCode}, 32'h00);
        end
        step("flush", 1'b0, 1'b1, 32'h01095020, 1'b1, 1'b1);
        check("flush_valid", {31'h0, bus.ex_valid}, 32'd0);

        step("illegal", 1'b0, 1'b1, 32'hFC000000, 1'b0, 1'b0);
        check("illegal_flag", {31'h0, bus.ex_illegal}, 32'd1);
        check("illegal_valid", {31'h0, bus.ex_valid}, 32'd1);
        step("illegal_inv", 1'b0, 1'b0, 32'hFC000000, 1'b0, 1'b0);
        check("illegal_inv_flag", {31'h0, bus.ex_illegal}, 32'd0);

        foreach (tbl[i]) step({"sweep_", tbl[i].name}, 1'b0, 1'b1, gen(tbl[i]), 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            w = ($urandom_range(0, 9) < 7) ? gen(tbl[$urandom_range(0, tbl.size() - 1)])
                                           : $urandom;
            step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) != 0), w,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
